// File: rtl/usb_rx_bit_ctrl.sv
// usb_rx_bit_ctrl: full-speed USB receive bit timing, bit destuffing, SYNC check and LSB-first byte assembly.
// Latency: shift_enable SAMPLE_PHASE cycles after a D+ edge; byte_received two cycles after the last bit's bit_valid.
// Backpressure: none; bytes arrive at line rate and must be taken on the byte_received pulse.
//
// Ports:
//   clk, n_rst                 system clock, asynchronous active-low reset
//   d_plus_sync, d_minus_sync  synchronized bus lines (J idle = D+ high)
//   d_orig                     decoded NRZI bit, valid the cycle after shift_enable
//   shift_enable               decoder sample strobe, one pulse per bit time
//   rx_byte, byte_received     last assembled byte and its one-cycle strobe
//   rcving                     packet in progress
//   packet_done                one-cycle pulse on a clean end of packet
//   r_error                    sticky error, cleared by the next packet's first edge
module usb_rx_bit_ctrl #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PHASE = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus_sync,
  input  logic       d_minus_sync,
  input  logic       d_orig,
  output logic       shift_enable,
  output logic [7:0] rx_byte,
  output logic       byte_received,
  output logic       rcving,
  output logic       packet_done,
  output logic       r_error
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PW-1:0] PHASE_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_PHASE);
  localparam logic [PW-1:0] PHASE_ONE    = PW'(1);
  localparam logic [7:0]    SYNC_BYTE    = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_RECEIVE,
    ST_EOP_WAIT,
    ST_ERROR
  } state_e;

  state_e          state_q, state_d;
  logic            prev_dp_q;
  logic [PW-1:0]   phase_q, phase_d;
  logic            bit_valid_q;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]      ones_cnt_q, ones_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            byte_done_q, byte_done_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            byte_rcvd_q, byte_rcvd_d;
  logic            r_error_q, r_error_d;
  logic            se0_seen_q, se0_seen_d;

  logic            edge_det;
  logic            line_se0;
  logic            in_rx;
  logic            se0_sample;
  logic            consume;
  logic            stuff_bit;
  logic            stuff_err;
  logic            data_bit;
  logic            clr_cnt;

  // ---------------------------------------------------------------------------
  // Line events
  // ---------------------------------------------------------------------------
  assign edge_det   = d_plus_sync ^ prev_dp_q;
  assign line_se0   = ~d_plus_sync & ~d_minus_sync;
  assign in_rx      = (state_q == ST_SYNC) || (state_q == ST_RECEIVE);

  // SE0 only matters at the bit sampling point while a packet is being decoded.
  assign se0_sample = shift_enable & line_se0;

  // The decoder presents d_orig one cycle after the strobe; bit_valid lines it up.
  assign consume    = bit_valid_q & in_rx;
  // After six consumed ones the transmitter must have inserted a zero.
  assign stuff_bit  = consume & (ones_cnt_q == 3'd6);
  assign stuff_err  = stuff_bit & d_orig;
  assign data_bit   = consume & ~stuff_bit;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (edge_det) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (se0_sample || stuff_err) begin
          state_d = ST_ERROR;
        end else if (byte_done_q) begin
          state_d = (shreg_q == SYNC_BYTE) ? ST_RECEIVE : ST_ERROR;
        end
      end
      ST_RECEIVE: begin
        // SE0 wins over a byte finishing in the same cycle; a clean EOP
        // requires the line to go SE0 on a byte boundary.
        if (se0_sample) begin
          state_d = (bit_cnt_q == 3'd0) ? ST_EOP_WAIT : ST_ERROR;
        end else if (stuff_err) begin
          state_d = ST_ERROR;
        end
      end
      ST_EOP_WAIT: begin
        if (d_plus_sync) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        // Drain the rest of the broken packet: SE0 first, then back to J.
        if (se0_seen_q && d_plus_sync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    shift_enable  = in_rx && (phase_q == PHASE_SAMPLE);
    rcving        = (state_q == ST_SYNC) || (state_q == ST_RECEIVE) ||
                    (state_q == ST_EOP_WAIT);
    packet_done   = (state_q == ST_EOP_WAIT) && d_plus_sync;
    rx_byte       = rx_byte_q;
    byte_received = byte_rcvd_q;
    r_error       = r_error_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // Phase 0 is the edge cycle itself, so the register lands on 1 after it.
    if (edge_det) begin
      phase_d = PHASE_ONE;
    end else if (phase_q == PHASE_LAST) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + 1'b1;
    end

    bit_cnt_d   = bit_cnt_q;
    ones_cnt_d  = ones_cnt_q;
    shreg_d     = shreg_q;
    byte_done_d = 1'b0;

    if (data_bit) begin
      shreg_d     = {d_orig, shreg_q[7:1]};
      bit_cnt_d   = bit_cnt_q + 3'd1;
      byte_done_d = (bit_cnt_q == 3'd7);
      ones_cnt_d  = d_orig ? (ones_cnt_q + 3'd1) : 3'd0;
    end
    if (stuff_bit) begin
      ones_cnt_d = 3'd0;
    end

    // Start every packet attempt, and every return to idle, with clean counters.
    clr_cnt = (state_d != state_q) &&
              ((state_d == ST_SYNC) || (state_d == ST_IDLE));
    if (clr_cnt) begin
      bit_cnt_d   = 3'd0;
      ones_cnt_d  = 3'd0;
      byte_done_d = 1'b0;
    end

    // Only payload bytes are published; the SYNC byte is consumed silently.
    byte_rcvd_d = (state_q == ST_RECEIVE) && byte_done_q && !se0_sample && !stuff_err;
    rx_byte_d   = byte_rcvd_d ? shreg_q : rx_byte_q;

    r_error_d = r_error_q;
    if ((state_q == ST_IDLE) && edge_det) begin
      r_error_d = 1'b0;
    end else if ((state_d == ST_ERROR) && (state_q != ST_ERROR)) begin
      r_error_d = 1'b1;
    end

    se0_seen_d = (state_q == ST_ERROR) && (se0_seen_q || line_se0);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_dp_q   <= 1'b1;
      phase_q     <= '0;
      bit_valid_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      ones_cnt_q  <= 3'd0;
      shreg_q     <= 8'h00;
      byte_done_q <= 1'b0;
      rx_byte_q   <= 8'h00;
      byte_rcvd_q <= 1'b0;
      r_error_q   <= 1'b0;
      se0_seen_q  <= 1'b0;
    end else begin
      prev_dp_q   <= d_plus_sync;
      phase_q     <= phase_d;
      bit_valid_q <= shift_enable;
      bit_cnt_q   <= bit_cnt_d;
      ones_cnt_q  <= ones_cnt_d;
      shreg_q     <= shreg_d;
      byte_done_q <= byte_done_d;
      rx_byte_q   <= rx_byte_d;
      byte_rcvd_q <= byte_rcvd_d;
      r_error_q   <= r_error_d;
      se0_seen_q  <= se0_seen_d;
    end
  end

endmodule

// File: tb/tb_usb_rx_bit_ctrl.sv
`timescale 1ns/1ps
module tb_usb_rx_bit_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       dp, dm, d_orig;
  logic       shift_enable;
  logic [7:0] rx_byte;
  logic       byte_received, rcving, packet_done, r_error;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  usb_rx_bit_ctrl #(.CLKS_PER_BIT(8), .SAMPLE_PHASE(3)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_plus_sync  (dp),
    .d_minus_sync (dm),
    .d_orig       (d_orig),
    .shift_enable (shift_enable),
    .rx_byte      (rx_byte),
    .byte_received(byte_received),
    .rcving       (rcving),
    .packet_done  (packet_done),
    .r_error      (r_error)
  );

  // Transmitter-side view of a packet: the payload the host meant to send and
  // the decoded bit stream (with stuffing) that goes on the wire.
  logic [7:0] pay_q[$];
  bit         tx_q[$];
  int         viol_idx;
  logic       line_lvl;

  // Observations gathered on the falling edge.
  int         cyc = 0;
  int         last_edge = 0;
  logic       dp_prev_mon = 1'b1;
  logic [7:0] got_q[$];
  int         se_cyc[$];
  int         se_cnt, se_bad, pd_cnt, pd_rcv_bad, fall_cnt, act_cnt;
  int         err_rise_cyc;
  logic       err_rise_rcv;
  logic       rcving_prev = 1'b0;
  logic       r_error_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (dp !== dp_prev_mon) last_edge = cyc;
    dp_prev_mon = dp;
    if (shift_enable === 1'b1) begin
      se_cnt++;
      se_cyc.push_back(cyc);
      if (((cyc - last_edge) % 8) != 3) se_bad++;
    end
    if (byte_received === 1'b1) got_q.push_back(rx_byte);
    if (packet_done === 1'b1) begin
      pd_cnt++;
      if (rcving !== 1'b1) pd_rcv_bad++;
    end
    if (rcving_prev === 1'b1 && rcving === 1'b0) fall_cnt++;
    if (r_error === 1'b1 && r_error_prev !== 1'b1 && err_rise_cyc < 0) begin
      err_rise_cyc = cyc;
      err_rise_rcv = rcving;
    end
    if (rcving === 1'b1 || r_error === 1'b1 || packet_done === 1'b1 || byte_received === 1'b1)
      act_cnt++;
    rcving_prev  = rcving;
    r_error_prev = r_error;
  end

  task automatic clear_mon();
    got_q.delete();
    se_cyc.delete();
    se_cnt = 0; se_bad = 0; pd_cnt = 0; pd_rcv_bad = 0; fall_cnt = 0; act_cnt = 0;
    err_rise_cyc = -1;
    err_rise_rcv = 1'b0;
  endtask

  // Sync byte then payload, LSB first, a zero inserted after every six ones.
  // With violate set, the first required stuff bit is sent as a one instead.
  function automatic void build(input logic [7:0] sync_b, input bit violate);
    logic [7:0] b;
    int ones;
    ones = 0;
    tx_q.delete();
    viol_idx = -1;
    for (int k = 0; k <= pay_q.size(); k++) begin
      if (k == 0) b = sync_b;
      else        b = pay_q[k-1];
      for (int i = 0; i < 8; i++) begin
        tx_q.push_back(b[i]);
        ones = b[i] ? ones + 1 : 0;
        if (ones == 6) begin
          if (violate && viol_idx < 0) begin
            tx_q.push_back(1'b1);
            viol_idx = tx_q.size() - 1;
          end else begin
            tx_q.push_back(1'b0);
          end
          ones = 0;
        end
      end
    end
  endfunction

  task automatic drive(input logic p, input logic m, input logic o, input int n);
    dp = p; dm = m; d_orig = o;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // NRZI on the wire: a zero toggles the line. Jitter stretches or shrinks
  // only bits that start with an edge, so the receiver can always resync.
  task automatic tx_send(input int from, input int upto, input bit jitter);
    int len;
    for (int i = from; i < upto && i < tx_q.size(); i++) begin
      len = 8;
      if (tx_q[i] == 1'b0) begin
        line_lvl = ~line_lvl;
        if (jitter) len = 7 + $urandom_range(0, 2);
      end
      drive(line_lvl, ~line_lvl, tx_q[i], len);
    end
  endtask

  task automatic tx_eop();
    drive(1'b0, 1'b0, 1'b0, 16);
    line_lvl = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 24);
  endtask

  task automatic test_reset();
    n_rst = 1'b1; dp = 1'b1; dm = 1'b0; d_orig = 1'b0; line_lvl = 1'b1;
    clear_mon();
    #2 n_rst = 1'b0;
    #1;
    vectors++; if ({shift_enable, byte_received, rcving, packet_done, r_error} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {shift_enable, byte_received, rcving, packet_done, r_error}); end
    vectors++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte); end
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    clear_mon();
    repeat (100) @(posedge clk);
    #1;
    vectors++; if (se_cnt !== 0) begin errors++; $display("FAIL idle_shift_enable: got %0d strobes want 0", se_cnt); end
    vectors++; if (act_cnt !== 0) begin errors++; $display("FAIL idle_outputs: got %0d active cycles want 0", act_cnt); end
    vectors++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL idle_rx_byte: got %h want 00", rx_byte); end
  endtask

  task automatic test_clean_packet();
    clear_mon();
    pay_q = '{8'hA5};
    build(8'h80, 1'b0);
    tx_send(0, tx_q.size(), 1'b0);
    tx_eop();
    vectors++; if (got_q.size() !== 1) begin errors++; $display("FAIL clean_count: got %0d bytes want 1", got_q.size()); end
    else begin vectors++; if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL clean_byte: got %h want a5", got_q[0]); end end
    vectors++; if (pd_cnt !== 1) begin errors++; $display("FAIL clean_packet_done: got %0d want 1", pd_cnt); end
    vectors++; if (pd_rcv_bad !== 0) begin errors++; $display("FAIL clean_rcving_at_done: got %0d low want 0", pd_rcv_bad); end
    vectors++; if (fall_cnt !== 1) begin errors++; $display("FAIL clean_rcving_fall: got %0d want 1", fall_cnt); end
    vectors++; if (r_error !== 1'b0) begin errors++; $display("FAIL clean_r_error: got %b want 0", r_error); end
    vectors++; if (se_cnt !== tx_q.size() + 1) begin errors++; $display("FAIL clean_strobes: got %0d want %0d", se_cnt, tx_q.size() + 1); end
    vectors++; if (se_bad !== 0) begin errors++; $display("FAIL clean_strobe_phase: got %0d off-phase want 0", se_bad); end
  endtask

  task automatic test_stuffing();
    clear_mon();
    pay_q = '{8'h3F, 8'hFF};
    build(8'h80, 1'b0);
    tx_send(0, tx_q.size(), 1'b0);
    tx_eop();
    vectors++; if (got_q.size() !== 2) begin errors++; $display("FAIL stuff_count: got %0d bytes want 2", got_q.size()); end
    else begin
      vectors++; if (got_q[0] !== 8'h3F) begin errors++; $display("FAIL stuff_byte0: got %h want 3f", got_q[0]); end
      vectors++; if (got_q[1] !== 8'hFF) begin errors++; $display("FAIL stuff_byte1: got %h want ff", got_q[1]); end
    end
    vectors++; if (pd_cnt !== 1) begin errors++; $display("FAIL stuff_packet_done: got %0d want 1", pd_cnt); end
    vectors++; if (r_error !== 1'b0) begin errors++; $display("FAIL stuff_r_error: got %b want 0", r_error); end
    vectors++; if (se_cnt !== tx_q.size() + 1) begin errors++; $display("FAIL stuff_strobes: got %0d want %0d", se_cnt, tx_q.size() + 1); end
  endtask

  task automatic test_stuff_violation();
    int dv;
    clear_mon();
    pay_q = '{8'hFF, 8'($urandom)};
    build(8'h80, 1'b1);
    tx_send(0, tx_q.size(), 1'b0);
    tx_eop();
    vectors++;
    if (se_cyc.size() <= viol_idx || err_rise_cyc < 0) begin
      errors++; $display("FAIL viol_timing: strobes %0d error_rise %0d, violation bit %0d", se_cyc.size(), err_rise_cyc, viol_idx);
    end else begin
      dv = err_rise_cyc - (se_cyc[viol_idx] + 1);
      if (dv < 1 || dv > 2) begin errors++; $display("FAIL viol_timing: got %0d cycles after bit_valid want 1..2", dv); end
      vectors++; if (err_rise_rcv !== 1'b0) begin errors++; $display("FAIL viol_rcving: got %b at error want 0", err_rise_rcv); end
    end
    vectors++; if (got_q.size() !== 0) begin errors++; $display("FAIL viol_bytes: got %0d want 0", got_q.size()); end
    vectors++; if (pd_cnt !== 0) begin errors++; $display("FAIL viol_packet_done: got %0d want 0", pd_cnt); end
    vectors++; if (r_error !== 1'b1) begin errors++; $display("FAIL viol_sticky: got %b want 1", r_error); end
    vectors++; if (rcving !== 1'b0) begin errors++; $display("FAIL viol_idle: got rcving %b want 0", rcving); end
  endtask

  task automatic test_bad_sync();
    clear_mon();
    pay_q = '{8'($urandom)};
    build(8'h81, 1'b0);
    tx_send(0, tx_q.size(), 1'b0);
    tx_eop();
    vectors++; if (r_error !== 1'b1) begin errors++; $display("FAIL badsync_r_error: got %b want 1", r_error); end
    vectors++; if (got_q.size() !== 0) begin errors++; $display("FAIL badsync_bytes: got %0d want 0", got_q.size()); end
    vectors++; if (pd_cnt !== 0) begin errors++; $display("FAIL badsync_packet_done: got %0d want 0", pd_cnt); end
    // The next good packet must clear the flag at its first edge.
    clear_mon();
    pay_q = '{8'($urandom)};
    build(8'h80, 1'b0);
    tx_send(0, 1, 1'b0);
    vectors++; if (r_error !== 1'b0) begin errors++; $display("FAIL badsync_clear: got %b want 0", r_error); end
    vectors++; if (rcving !== 1'b1) begin errors++; $display("FAIL badsync_restart: got rcving %b want 1", rcving); end
    tx_send(1, tx_q.size(), 1'b0);
    tx_eop();
    vectors++; if (got_q.size() !== 1) begin errors++; $display("FAIL recover_count: got %0d want 1", got_q.size()); end
    else begin vectors++; if (got_q[0] !== pay_q[0]) begin errors++; $display("FAIL recover_byte: got %h want %h", got_q[0], pay_q[0]); end end
  endtask

  task automatic test_random_packets(input bit jitter, input int npkt);
    int n;
    for (int p = 0; p < npkt; p++) begin
      clear_mon();
      n = $urandom_range(1, 3);
      pay_q.delete();
      for (int k = 0; k < n; k++) pay_q.push_back(8'($urandom));
      build(8'h80, 1'b0);
      tx_send(0, tx_q.size(), jitter);
      tx_eop();
      vectors++;
      if (got_q.size() !== n) begin errors++; $display("FAIL rand_count: pkt %0d got %0d bytes want %0d", p, got_q.size(), n); end
      else for (int k = 0; k < n; k++) begin
        vectors++; if (got_q[k] !== pay_q[k]) begin errors++; $display("FAIL rand_byte: pkt %0d byte %0d got %h want %h", p, k, got_q[k], pay_q[k]); end
      end
      vectors++; if (pd_cnt !== 1) begin errors++; $display("FAIL rand_packet_done: pkt %0d got %0d want 1", p, pd_cnt); end
      vectors++; if (r_error !== 1'b0) begin errors++; $display("FAIL rand_r_error: pkt %0d got %b want 0", p, r_error); end
      vectors++; if (se_bad !== 0) begin errors++; $display("FAIL rand_phase: pkt %0d got %0d off-phase strobes want 0", p, se_bad); end
      vectors++; if (se_cnt !== tx_q.size() + 1) begin errors++; $display("FAIL rand_strobes: pkt %0d got %0d want %0d", p, se_cnt, tx_q.size() + 1); end
    end
  endtask

  task automatic test_se0_midbyte();
    clear_mon();
    pay_q = '{8'($urandom)};
    build(8'h80, 1'b0);
    tx_send(0, 12, 1'b1);
    tx_eop();
    vectors++; if (r_error !== 1'b1) begin errors++; $display("FAIL se0mid_r_error: got %b want 1", r_error); end
    vectors++; if (got_q.size() !== 0) begin errors++; $display("FAIL se0mid_bytes: got %0d want 0", got_q.size()); end
    vectors++; if (pd_cnt !== 0) begin errors++; $display("FAIL se0mid_packet_done: got %0d want 0", pd_cnt); end
    vectors++; if (rcving !== 1'b0) begin errors++; $display("FAIL se0mid_rcving: got %b want 0", rcving); end
  endtask

  task automatic test_reset_midpacket();
    clear_mon();
    pay_q = '{8'hA5, 8'($urandom)};
    build(8'h80, 1'b0);
    tx_send(0, 19, 1'b0);
    vectors++; if (rcving !== 1'b1) begin errors++; $display("FAIL midrst_pre_rcving: got %b want 1", rcving); end
    vectors++; if (got_q.size() !== 1 || rx_byte !== 8'hA5) begin
      errors++; $display("FAIL midrst_pre_byte: got %0d bytes rx %h want 1 a5", got_q.size(), rx_byte); end
    n_rst = 1'b0;
    #1;
    vectors++; if ({shift_enable, byte_received, rcving, packet_done, r_error} !== 5'b0) begin
      errors++; $display("FAIL midrst_flags: got %b want 00000", {shift_enable, byte_received, rcving, packet_done, r_error}); end
    vectors++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL midrst_rx_byte: got %h want 00", rx_byte); end
    line_lvl = 1'b1;
    dp = 1'b1; dm = 1'b0;
    @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    vectors++; if (pd_cnt !== 0 || got_q.size() !== 1) begin
      errors++; $display("FAIL midrst_after: got %0d done %0d bytes want 0 1", pd_cnt, got_q.size()); end
    vectors++; if (rcving !== 1'b0) begin errors++; $display("FAIL midrst_idle: got rcving %b want 0", rcving); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_clean_packet();
    test_stuffing();
    test_stuff_violation();
    test_bad_sync();
    test_random_packets(1'b0, 6);
    test_random_packets(1'b1, 4);
    test_se0_midbyte();
    test_reset_midpacket();
    test_clean_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/usb_rx_bit_ctrl.md
Name: usb_rx_bit_ctrl

Overview:
Receive-side bit-timing and packet-sequencing controller for the USB full-speed receive path. It recovers bit timing from d_plus_sync edges and generates shift_enable for the NRZI decoder. It consumes the decoder's d_orig output, removes stuffed bits, checks the SYNC byte, assembles bytes LSB-first, and detects EOP and framing errors.

Parameters:
CLKS_PER_BIT, 8, clock cycles per USB bit; phase counter width is clog2(CLKS_PER_BIT).
SAMPLE_PHASE, 3, phase value at which shift_enable is asserted; range 1..CLKS_PER_BIT-1.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
d_plus_sync  input  1  synchronized D+ line
d_minus_sync  input  1  synchronized D- line
d_orig  input  1  decoded bit from NRZI decoder; valid the cycle after shift_enable
shift_enable  output  1  decoder sample strobe, one-cycle pulse per bit
rx_byte  output  8  last assembled byte, LSB received first
byte_received  output  1  one-cycle pulse; rx_byte updated in the same cycle
rcving  output  1  high while a packet is in progress
packet_done  output  1  one-cycle pulse on a clean EOP
r_error  output  1  sticky receive-error flag

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, n_rst). During reset all outputs are 0 and state is IDLE. Internal registers reset as follows: prev_dp=1, phase=0, bit_cnt=0, ones_cnt=0.
- Edge detect: edge = d_plus_sync != prev_dp. prev_dp registers d_plus_sync every cycle.
- Phase counter: increments mod CLKS_PER_BIT every cycle. An edge in cycle N counts as phase 0, so phase=1 in cycle N+1.
- shift_enable: combinational from registers, equal to (phase==SAMPLE_PHASE) && state in {SYNC, RECEIVE}. With defaults, an edge in cycle N gives shift_enable in cycle N+3, absent further edges.
- bit_valid: shift_enable delayed one cycle. d_orig is consumed only when bit_valid=1.
- SE0 check: d_plus_sync==0 && d_minus_sync==0, evaluated in shift_enable cycles.
- Bit stuffing:
  - ones_cnt counts consecutive consumed 1s and clears on a consumed 0.
  - When ones_cnt==6, the next consumed bit is stuffed. It is discarded (no bit_cnt or rx shift) and ones_cnt clears.
  - A stuffed bit equal to 1 causes a stuff error, which leads to ERROR.
- Byte assembly:
  - Each non-stuffed consumed bit shifts into bit 7 of a shift register (right shift) and increments bit_cnt.
  - On the 8th bit, bit_cnt wraps to 0 and the full byte is produced the following cycle.
- State machine:
  - IDLE: rcving=0. On an edge, set r_error=0 and go to SYNC; phase resyncs.
  - SYNC: rcving=1. On byte completion, if the byte == 8'h80, go to RECEIVE with no byte_received; otherwise set r_error=1 and go to ERROR. SE0 in this state causes r_error=1 and a move to ERROR.
  - RECEIVE: rcving=1. On byte completion, set rx_byte and pulse byte_received. On SE0 with bit_cnt==0, go to EOP_WAIT. On SE0 with bit_cnt!=0, or on a stuff error, set r_error=1 and go to ERROR.
  - EOP_WAIT: rcving=1. When d_plus_sync==1, pulse packet_done for one cycle, set rcving=0 next cycle, and go to IDLE.
  - ERROR: rcving=0 and r_error held. Wait for SE0 (d_plus_sync==0 && d_minus_sync==0 at any cycle), then for d_plus_sync==1, then go to IDLE. r_error stays set until the next packet start.
- Simultaneous events: SE0 takes priority over byte completion in the same cycle. A stuff error takes priority over byte completion.
- Reset mid-packet aborts immediately to IDLE. No packet_done or byte_received is produced.
- Counter clearing: bit_cnt and ones_cnt clear on entry to SYNC and on entry to IDLE.

Test Plan:
1. Reset, then an idle J line for 100 cycles -> all outputs 0, no shift_enable.
2. Clean packet: SYNC, then byte 0xA5, then SE0 for 2 bits, then J -> one byte_received with rx_byte=8'hA5, packet_done 1 cycle, r_error=0, rcving high from the first edge until after packet_done.
3. Byte 0x3F followed by 0xFF (six 1s then a stuffed 0) -> rx_byte sequence 8'h3F, 8'hFF. The stuffed bit is not counted; exactly two byte_received pulses.
4. Stuff violation: seven consecutive 1s -> r_error=1 and rcving=0 within 2 cycles of the 7th bit's bit_valid. No further byte_received; return to IDLE after SE0+J.
5. Bad SYNC pattern 8'h81 -> r_error=1, no byte_received. The next valid packet clears r_error at its first edge.
6. Phase tracking: edges jittered ±1 cycle around the 8-cycle nominal -> shift_enable is always 3 cycles after the last edge. SE0 after 4 bits gives r_error=1; n_rst pulsed mid-packet gives all outputs 0 immediately.
